settings_bus_arbiter: RTL and testbench
=======================================

# settings_bus_arbiter

Shares one settings bus (set_stb/set_addr/set_data write port plus get_stb/get_addr/get_data read port, as consumed by global_settings and the per-stream register pages) between several bus masters, e.g. the host AXI-lite bridge and internal stream engines. Requests are arbitrated round-robin and issued as single-cycle strobes. Read data is captured and returned to the winning master with a one-cycle response pulse.

## Interface
- C_DATAWIDTH, 32, settings data width
- C_ADDRWIDTH, 32, settings address width
- C_NUM_MASTERS, 2, number of requesters (1..8)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  C_NUM_MASTERS  per-master request pending
- req_write  in  C_NUM_MASTERS  1 = write (set), 0 = read (get)
- req_addr  in  C_NUM_MASTERS*C_ADDRWIDTH  packed; master i at [i*AW +: AW]
- req_data  in  C_NUM_MASTERS*C_DATAWIDTH  packed write data
- req_ready  out  C_NUM_MASTERS  one-hot accept pulse
- rsp_valid  out  C_NUM_MASTERS  one-hot completion pulse
- rsp_data  out  C_NUM_MASTERS*C_DATAWIDTH  packed read data; 0 for writes
- set_data  out  C_DATAWIDTH  to settings slaves
- set_addr  out  C_ADDRWIDTH  to settings slaves
- set_stb  out  1  write strobe
- get_addr  out  C_ADDRWIDTH  to settings slaves
- get_stb  out  1  read strobe
- get_data  in  C_DATAWIDTH  combinational read data from slaves, valid while get_stb high

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid, pick the winner round-robin, searching from (last_grant+1) mod N.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Register the winner's write flag, addr and data, plus the winner index.
  - Update last_grant to the winner and go to ISSUE.
- ISSUE:
  - Write: set_stb=1, with set_addr/set_data from the captured request.
  - Read: get_stb=1, with get_addr from the captured request; capture get_data at the end of this cycle.
  - Exactly one strobe is high for exactly one cycle. Go to RESP.
- RESP:
  - rsp_valid[winner]=1 for one cycle.
  - rsp_data slice = captured read data, or 0 for a write.
  - Return to IDLE.
- Masters hold req_valid/addr/data/write stable until req_ready. Valid still high in the cycle after ready counts as a new request.
- set_addr, set_data and get_addr hold their last issued value when idle. Only the strobes return to 0.
- rsp_data slices hold their last value until the next response to that master.
- Simultaneous requests: exactly one is granted; the others wait, with no starvation (each waits at most N-1 transactions).
- Reset mid-transaction: the transaction is abandoned, with no strobe and no rsp_valid after the reset edge. last_grant = N-1, so master 0 has priority first.
- C_NUM_MASTERS=1: degenerates to a fixed grant with the same timing.

## Timing
- Reset values:
  - state=IDLE, last_grant=N-1.
  - req_ready=0, rsp_valid=0, set_stb=0, get_stb=0.
  - set_addr, set_data, get_addr, rsp_data all 0.
- Request accepted in cycle T (req_ready high) -> strobe in T+1 -> rsp_valid in T+2.
- Next acceptance is possible at T+3, so throughput is one transaction per 3 cycles.
- req_ready depends combinationally on req_valid and the state. All other outputs are registered.

## Structure
- Package settings_bus_pkg holds:
  - state encoding localparams (IDLE/ISSUE/RESP)
  - width of the grant index, $clog2(C_NUM_MASTERS) with a minimum of 1
- Sub-module rr_arbiter:
  - inputs: request vector and last_grant
  - outputs: one-hot grant and encoded index
  - purely combinational; parameterised by N
- The top level holds the FSM, capture registers and packing/unpacking.

## Test plan
- Reset, then master 0 reads addr 0x0 against global_settings: req_ready[0] at T, get_stb at T+1 with get_addr=0x0, rsp_valid[0] at T+2 with rsp_data=0xACE0BA53.
- Master 1 writes 0x0000001F to addr 0x4: set_stb for one cycle with set_addr=0x4 and set_data=0x1F. rsp_valid[1] with rsp_data=0. A follow-up read of 0x4 returns 0x1F.
- Both masters request in the same cycle after reset: master 0 is granted first, then master 1 at T+3. Repeat with both held: grants alternate 0,1,0,1.
- Master 0 requests continuously while master 1 is idle: master 0 is granted every 3 cycles with no bubbles beyond the FSM.
- Assert rst during ISSUE: no strobe and no rsp_valid after the edge, all outputs at reset values. The next simultaneous request grants master 0.
- Random mix of 1000 reads and writes from 3 masters against a register model: every request gets exactly one req_ready and one rsp_valid, in order per master. set_stb and get_stb are never high together.

Source files
------------

// File: rtl/settings_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// settings_bus_pkg : shared FSM encoding and index-width helper for the
//                    settings bus arbiter.
// Rev 1.0
// ============================================================================
package settings_bus_pkg;

   localparam logic [1:0] C_ST_IDLE  = 2'd0;
   localparam logic [1:0] C_ST_ISSUE = 2'd1;
   localparam logic [1:0] C_ST_RESP  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = C_ST_IDLE,
      S_ISSUE = C_ST_ISSUE,
      S_RESP  = C_ST_RESP
   } state_t;

   // Grant index width; a single master still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/settings_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// settings_req_if / settings_bus_if : requester-side and slave-side bundles
//                                     of the settings bus arbiter.
// Rev 1.0
// ============================================================================
interface settings_req_if #(
   parameter int C_NUM_MASTERS = 2,
   parameter int C_ADDRWIDTH   = 32,
   parameter int C_DATAWIDTH   = 32
);
   logic [C_NUM_MASTERS-1:0]             req_valid;
   logic [C_NUM_MASTERS-1:0]             req_write;
   logic [C_NUM_MASTERS*C_ADDRWIDTH-1:0] req_addr;
   logic [C_NUM_MASTERS*C_DATAWIDTH-1:0] req_data;
   logic [C_NUM_MASTERS-1:0]             req_ready;
   logic [C_NUM_MASTERS-1:0]             rsp_valid;
   logic [C_NUM_MASTERS*C_DATAWIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

interface settings_bus_if #(
   parameter int C_ADDRWIDTH = 32,
   parameter int C_DATAWIDTH = 32
);
   logic                   set_stb;
   logic [C_ADDRWIDTH-1:0] set_addr;
   logic [C_DATAWIDTH-1:0] set_data;
   logic                   get_stb;
   logic [C_ADDRWIDTH-1:0] get_addr;
   logic [C_DATAWIDTH-1:0] get_data;

   modport master (
      output set_stb, set_addr, set_data, get_stb, get_addr,
      input  get_data
   );

   modport slave (
      input  set_stb, set_addr, set_data, get_stb, get_addr,
      output get_data
   );
endinterface
`default_nettype wire

// File: rtl/settings_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin picker, searching from last_grant+1.
// Rev 1.0
// ============================================================================
module rr_arbiter
   import settings_bus_pkg::*;
#(
   parameter int N      = 2,
   parameter int C_IDXW = idx_width(N)
) (
   input  wire logic [N-1:0]      i_req,
   input  wire logic [C_IDXW-1:0] i_last,
   output logic      [N-1:0]      o_grant,
   output logic      [C_IDXW-1:0] o_idx
);

   logic w_found;

   // Offset k walks the rotation; the first requesting slot wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!w_found && (i == ((int'(i_last) + 1 + k) % N)) && i_req[i]) begin
               w_found    = 1'b1;
               o_grant[i] = 1'b1;
               o_idx      = C_IDXW'(i);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/settings_bus_arbiter.sv
`default_nettype none
// ============================================================================
// settings_bus_arbiter : round-robin sharing of one settings bus between
//                        several masters; accept -> strobe -> response.
// Rev 1.0
// ============================================================================
module settings_bus_arbiter
   import settings_bus_pkg::*;
#(
   parameter int C_DATAWIDTH   = 32,
   parameter int C_ADDRWIDTH   = 32,
   parameter int C_NUM_MASTERS = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   settings_req_if.slave  req_if,
   settings_bus_if.master bus_if
);

   localparam int N      = C_NUM_MASTERS;
   localparam int C_IDXW = idx_width(N);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [C_IDXW-1:0]      r_last;
   logic [C_IDXW-1:0]      r_idx;
   logic [C_IDXW-1:0]      w_win_idx;
   logic [N-1:0]           w_grant;
   logic [N-1:0]           w_ready;
   logic                   w_accept;
   logic                   w_sel_write;
   logic [C_ADDRWIDTH-1:0] w_sel_addr;
   logic [C_DATAWIDTH-1:0] w_sel_data;
   logic                   r_set_stb;
   logic                   r_get_stb;
   logic [C_ADDRWIDTH-1:0] r_set_addr;
   logic [C_DATAWIDTH-1:0] r_set_data;
   logic [C_ADDRWIDTH-1:0] r_get_addr;
   logic [N-1:0]           r_rsp_valid;
   logic [N*C_DATAWIDTH-1:0] r_rsp_data;

   rr_arbiter #(
      .N      (N),
      .C_IDXW (C_IDXW)
   ) u_rr_arbiter (
      .i_req   (req_if.req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_win_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = '0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|req_if.req_valid) begin
               w_accept     = 1'b1;
               w_ready      = w_grant;
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_sel_write = req_if.req_write[i];
            w_sel_addr  = req_if.req_addr[i*C_ADDRWIDTH +: C_ADDRWIDTH];
            w_sel_data  = req_if.req_data[i*C_DATAWIDTH +: C_DATAWIDTH];
         end
      end
   end

   // The strobe registers double as the captured write/read flag while in ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last      <= C_IDXW'(N - 1);
         r_idx       <= '0;
         r_set_stb   <= 1'b0;
         r_get_stb   <= 1'b0;
         r_set_addr  <= '0;
         r_set_data  <= '0;
         r_get_addr  <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_set_stb   <= 1'b0;
         r_get_stb   <= 1'b0;
         r_rsp_valid <= '0;
         if (w_accept) begin
            r_idx  <= w_win_idx;
            r_last <= w_win_idx;
            if (w_sel_write) begin
               r_set_stb  <= 1'b1;
               r_set_addr <= w_sel_addr;
               r_set_data <= w_sel_data;
            end else begin
               r_get_stb  <= 1'b1;
               r_get_addr <= w_sel_addr;
            end
         end
         if (r_state == S_ISSUE) begin
            for (int i = 0; i < N; i++) begin
               if (i == int'(r_idx)) begin
                  r_rsp_valid[i] <= 1'b1;
                  r_rsp_data[i*C_DATAWIDTH +: C_DATAWIDTH] <=
                     r_set_stb ? '0 : bus_if.get_data;
               end
            end
         end
      end
   end

   assign req_if.req_ready = w_ready;
   assign req_if.rsp_valid = r_rsp_valid;
   assign req_if.rsp_data  = r_rsp_data;
   assign bus_if.set_stb   = r_set_stb;
   assign bus_if.set_addr  = r_set_addr;
   assign bus_if.set_data  = r_set_data;
   assign bus_if.get_stb   = r_get_stb;
   assign bus_if.get_addr  = r_get_addr;

endmodule
`default_nettype wire

// File: tb/tb_settings_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_settings_bus_arbiter : directed and randomized checks of the arbiter with
//                           three masters against a small register-file slave.
// Rev 1.0
// ============================================================================
module tb_settings_bus_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   bit   mon_en;
   int   rdy_cnt [NM];
   int   rsp_cnt [NM];
   int   both_hi;
   logic [31:0] mem    [0:15];
   logic [31:0] shadow [0:15];

   settings_req_if #(.C_NUM_MASTERS(NM), .C_ADDRWIDTH(AW), .C_DATAWIDTH(DW)) rq ();
   settings_bus_if #(.C_ADDRWIDTH(AW), .C_DATAWIDTH(DW)) sb ();

   settings_bus_arbiter #(
      .C_DATAWIDTH   (DW),
      .C_ADDRWIDTH   (AW),
      .C_NUM_MASTERS (NM)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_if (rq),
      .bus_if (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: word 0 is the read-only global_settings signature.
   assign sb.get_data = (sb.get_addr[5:2] == 4'd0) ? 32'hACE0BA53 : mem[sb.get_addr[5:2]];
   always @(posedge clk) begin
      if (sb.set_stb && sb.set_addr[5:2] != 4'd0) mem[sb.set_addr[5:2]] <= sb.set_data;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         #2;
         for (int i = 0; i < NM; i++) begin
            if (rq.req_ready[i]) rdy_cnt[i]++;
            if (rq.rsp_valid[i]) rsp_cnt[i]++;
         end
         if (sb.set_stb && sb.get_stb) both_hi++;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [NM-1:0] onehot(input int m);
      onehot    = '0;
      onehot[m] = 1'b1;
   endfunction

   task automatic set_req(input int m, input bit v, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
      rq.req_valid[m]           = v;
      rq.req_write[m]           = wr;
      rq.req_addr[m*AW +: AW]   = a;
      rq.req_data[m*DW +: DW]   = d;
   endtask

   // Starts and ends at a negedge with the arbiter idle.
   task automatic txn(input int m, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
      set_req(m, 1'b1, wr, a, d);
      #1;
      check_eq("txn_ready", rq.req_ready, onehot(m));
      @(negedge clk);
      rq.req_valid[m] = 1'b0;
      check_eq("txn_set_stb", sb.set_stb, wr);
      check_eq("txn_get_stb", sb.get_stb, !wr);
      check_eq("txn_ready_issue", rq.req_ready, 0);
      if (wr) begin
         check_eq("txn_set_addr", sb.set_addr, a);
         check_eq("txn_set_data", sb.set_data, d);
      end else begin
         check_eq("txn_get_addr", sb.get_addr, a);
      end
      @(negedge clk);
      check_eq("txn_rsp_valid", rq.rsp_valid, onehot(m));
      check_eq("txn_rsp_data", rq.rsp_data[m*DW +: DW], exp);
      check_eq("txn_stb_resp", {sb.set_stb, sb.get_stb}, 0);
      @(negedge clk);
      check_eq("txn_rsp_clear", rq.rsp_valid, 0);
   endtask

   task automatic driver(input int m, input int ntx);
      for (int t = 0; t < ntx; t++) begin
         bit          wr;
         bit          got;
         int          r;
         int          waited;
         logic [31:0] d;
         logic [31:0] ex;
         wr = 1'($urandom_range(0, 1));
         r  = $urandom_range(1, 7);
         d  = $urandom;
         set_req(m, 1'b1, wr, 32'(r * 4), d);
         got    = 1'b0;
         waited = 0;
         while (!got && waited < 100) begin
            #1;
            if (rq.req_ready[m]) got = 1'b1;
            else begin
               @(negedge clk);
               waited++;
            end
         end
         check_eq("rnd_accept", got, 1);
         if (!got) begin
            rq.req_valid[m] = 1'b0;
            break;
         end
         ex = wr ? 32'h0 : shadow[r];
         if (wr) shadow[r] = d;
         @(negedge clk);
         rq.req_valid[m] = 1'b0;
         @(negedge clk);
         check_eq("rnd_rsp_valid", rq.rsp_valid[m], 1);
         check_eq("rnd_rsp_data", rq.rsp_data[m*DW +: DW], ex);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      both_hi  = 0;
      for (int i = 0; i < NM; i++) begin
         rdy_cnt[i] = 0;
         rsp_cnt[i] = 0;
      end
      for (int i = 0; i < 16; i++) begin
         mem[i]    = 32'h0;
         shadow[i] = 32'h0;
      end
      rst          = 1'b1;
      rq.req_valid = '0;
      rq.req_write = '0;
      rq.req_addr  = '0;
      rq.req_data  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_ready", rq.req_ready, 0);
      check_eq("rst_rsp_valid", rq.rsp_valid, 0);
      check_eq("rst_set_stb", sb.set_stb, 0);
      check_eq("rst_get_stb", sb.get_stb, 0);
      check_eq("rst_set_addr", sb.set_addr, 0);
      check_eq("rst_set_data", sb.set_data, 0);
      check_eq("rst_get_addr", sb.get_addr, 0);
      check_eq("rst_rsp_data", |rq.rsp_data, 0);
      @(negedge clk);

      // Read signature, write then read back a register.
      txn(0, 1'b0, 32'h0, 32'h0, 32'hACE0BA53);
      txn(1, 1'b1, 32'h4, 32'h1F, 32'h0);
      check_eq("rsp_data_hold_m0", rq.rsp_data[31:0], 32'hACE0BA53);
      check_eq("set_addr_hold", sb.set_addr, 32'h4);
      txn(1, 1'b0, 32'h4, 32'h0, 32'h1F);
      shadow[1] = 32'h1F;

      // Simultaneous requests after reset alternate 0,1,0,1.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h4, 32'h0);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("alt_ready", rq.req_ready, onehot(k % 2));
         @(negedge clk);
         check_eq("alt_get_addr", sb.get_addr, (k % 2) ? 32'h4 : 32'h0);
         @(negedge clk);
         check_eq("alt_rsp_valid", rq.rsp_valid, onehot(k % 2));
         check_eq("alt_rsp_data", rq.rsp_data[(k%2)*DW +: DW], (k % 2) ? 32'h1F : 32'hACE0BA53);
         @(negedge clk);
      end
      rq.req_valid = '0;

      // Master 0 alone, held high: granted every third cycle.
      set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("cont_ready_T", rq.req_ready, 3'b001);
         @(negedge clk);
         check_eq("cont_ready_T1", rq.req_ready, 0);
         @(negedge clk);
         check_eq("cont_ready_T2", rq.req_ready, 0);
         @(negedge clk);
      end
      rq.req_valid = '0;

      // Reset during ISSUE abandons the transaction and restores priority.
      txn(1, 1'b0, 32'h4, 32'h0, 32'h1F);
      set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      check_eq("rstmid_ready", rq.req_ready, 3'b001);
      @(negedge clk);
      rq.req_valid[0] = 1'b0;
      check_eq("rstmid_issue_stb", sb.get_stb, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rstmid_rsp_valid", rq.rsp_valid, 0);
      check_eq("rstmid_stbs", {sb.set_stb, sb.get_stb}, 0);
      check_eq("rstmid_get_addr", sb.get_addr, 0);
      check_eq("rstmid_set_addr", sb.set_addr, 0);
      check_eq("rstmid_set_data", sb.set_data, 0);
      check_eq("rstmid_rsp_data", |rq.rsp_data, 0);
      rst = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h0, 32'h0);
      set_req(2, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      check_eq("rstmid_regrant", rq.req_ready, 3'b001);
      @(negedge clk);
      rq.req_valid = '0;
      check_eq("rstmid_no_rsp_stale", rq.rsp_valid, 0);
      @(negedge clk);
      check_eq("rstmid_new_rsp", rq.rsp_valid, 3'b001);
      @(negedge clk);

      // Randomized traffic from three masters.
      mon_en = 1'b1;
      @(negedge clk);
      fork
         driver(0, 334);
         driver(1, 333);
         driver(2, 333);
      join
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      check_eq("rnd_ready_cnt_m0", rdy_cnt[0], 334);
      check_eq("rnd_ready_cnt_m1", rdy_cnt[1], 333);
      check_eq("rnd_ready_cnt_m2", rdy_cnt[2], 333);
      check_eq("rnd_rsp_cnt_m0", rsp_cnt[0], 334);
      check_eq("rnd_rsp_cnt_m1", rsp_cnt[1], 333);
      check_eq("rnd_rsp_cnt_m2", rsp_cnt[2], 333);
      check_eq("rnd_both_strobes", both_hi, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
